// File: rtl/alarm_pkg.sv
// Shared types and helpers for the alarm sequencer.
// The optional ALARM_SEQ_AUTOSTOP_EN feature lives in alarm_channel.
package alarm_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRing,
    StSnooze
  } alarm_state_e;

  localparam int unsigned DefSnzTicks  = 300;
  localparam int unsigned DefStopTicks = 3;
  localparam int unsigned DefMaxSnooze = 3;
  localparam int unsigned DefRingTicks = 600;

  // Bits needed to index n values, never less than one.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: IDLE/RING/SNOOZE FSM with snooze counter and tick timer.
// Define ALARM_SEQ_AUTOSTOP_EN to return RING to IDLE after RING_TICKS ticks.
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int unsigned SNZ_TICKS  = DefSnzTicks,
  parameter int unsigned MAX_SNOOZE = DefMaxSnooze,
  parameter int unsigned RING_TICKS = DefRingTicks
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic match,
  input  logic enable,
  input  logic snz_press,
  input  logic stop_done,
  output logic ringing,
  output logic snoozing
);

`ifdef ALARM_SEQ_AUTOSTOP_EN
  localparam int unsigned TmrMax = (SNZ_TICKS > RING_TICKS) ? SNZ_TICKS : RING_TICKS;
`else
  localparam int unsigned TmrMax = SNZ_TICKS;
`endif
  localparam int unsigned TmrW = width_of(TmrMax + 1);
  localparam int unsigned CntW = width_of(MAX_SNOOZE + 1);

  alarm_state_e    state_q;
  logic [CntW-1:0] snz_cnt_q;
  logic [TmrW-1:0] timer_q;
  logic            snz_room;
  logic            snz_expire;

  assign snz_room   = 32'(snz_cnt_q) < MAX_SNOOZE;
  assign snz_expire = (32'(timer_q) + 32'd1) >= SNZ_TICKS;

`ifdef ALARM_SEQ_AUTOSTOP_EN
  logic ring_expire;
  assign ring_expire = (32'(timer_q) + 32'd1) >= RING_TICKS;
`else
  logic unused_ring_ticks;
  assign unused_ring_ticks = ^RING_TICKS;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      snz_cnt_q <= '0;
      timer_q   <= '0;
      ringing   <= 1'b0;
      snoozing  <= 1'b0;
    end else if (!enable || (stop_done && state_q != StIdle)) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      ringing  <= 1'b0;
      snoozing <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (match) begin
            state_q   <= StRing;
            snz_cnt_q <= '0;
            timer_q   <= '0;
            ringing   <= 1'b1;
            snoozing  <= 1'b0;
          end
        end
        StRing: begin
          if (snz_press && snz_room) begin
            state_q   <= StSnooze;
            snz_cnt_q <= snz_cnt_q + CntW'(1);
            timer_q   <= '0;
            ringing   <= 1'b0;
            snoozing  <= 1'b1;
          end
`ifdef ALARM_SEQ_AUTOSTOP_EN
          else if (tick) begin
            if (ring_expire) begin
              state_q   <= StIdle;
              snz_cnt_q <= '0;
              timer_q   <= '0;
              ringing   <= 1'b0;
              snoozing  <= 1'b0;
            end else begin
              timer_q <= timer_q + TmrW'(1);
            end
          end
`endif
        end
        StSnooze: begin
          if (tick) begin
            if (snz_expire) begin
              state_q  <= StRing;
              timer_q  <= '0;
              ringing  <= 1'b1;
              snoozing <= 1'b0;
            end else begin
              timer_q <= timer_q + TmrW'(1);
            end
          end
        end
        default: begin
          state_q  <= StIdle;
          timer_q  <= '0;
          ringing  <= 1'b0;
          snoozing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alarm_sequencer.sv
// Multi-channel alarm ring/snooze/stop sequencer with shared buttons and buzzer.
// ALARM_SEQ_AUTOSTOP_EN enables the per-channel RING auto-stop timeout.
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int unsigned NUM_ALARMS = 4,
  parameter int unsigned SNZ_TICKS  = DefSnzTicks,
  parameter int unsigned STOP_TICKS = DefStopTicks,
  parameter int unsigned MAX_SNOOZE = DefMaxSnooze,
  parameter int unsigned RING_TICKS = DefRingTicks
) (
  input  logic                            Clk,
  input  logic                            Rst_n,
  input  logic                            Tick,
  input  logic [NUM_ALARMS-1:0]           Match,
  input  logic [NUM_ALARMS-1:0]           Enable,
  input  logic                            SnzBtn,
  input  logic                            StopBtn,
  output logic [NUM_ALARMS-1:0]           Ringing,
  output logic [NUM_ALARMS-1:0]           Snoozing,
  output logic                            Buzzer,
  output logic                            RingValid,
  output logic [width_of(NUM_ALARMS)-1:0] RingId,
  output logic                            StopHold
);

  localparam int unsigned IdW   = width_of(NUM_ALARMS);
  localparam int unsigned HoldW = width_of(STOP_TICKS + 1);

  logic             snz_prev_q;
  logic [HoldW-1:0] hold_q;
  logic             inhibit_q;
  logic             snz_press;
  logic             any_active;
  logic             hold_last;
  logic             stop_done;

  assign snz_press  = SnzBtn & ~snz_prev_q;
  assign any_active = |(Ringing | Snoozing);
  assign hold_last  = (32'(hold_q) + 32'd1) >= STOP_TICKS;
  assign stop_done  = StopBtn & ~inhibit_q & Tick & any_active & hold_last;

  // After a completed stop the button must be released before it can count again.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      snz_prev_q <= 1'b0;
      hold_q     <= '0;
      inhibit_q  <= 1'b0;
    end else begin
      snz_prev_q <= SnzBtn;
      if (!StopBtn) begin
        hold_q    <= '0;
        inhibit_q <= 1'b0;
      end else if (stop_done) begin
        hold_q    <= '0;
        inhibit_q <= 1'b1;
      end else if (!inhibit_q && Tick && any_active) begin
        hold_q <= hold_q + HoldW'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_ch
    alarm_channel #(
      .SNZ_TICKS  (SNZ_TICKS),
      .MAX_SNOOZE (MAX_SNOOZE),
      .RING_TICKS (RING_TICKS)
    ) u_ch (
      .clk       (Clk),
      .rst_n     (Rst_n),
      .tick      (Tick),
      .match     (Match[g]),
      .enable    (Enable[g]),
      .snz_press (snz_press),
      .stop_done (stop_done),
      .ringing   (Ringing[g]),
      .snoozing  (Snoozing[g])
    );
  end

  always_comb begin
    RingId = '0;
    for (int i = int'(NUM_ALARMS) - 1; i >= 0; i--) begin
      if (Ringing[i]) RingId = IdW'(i);
    end
  end

  assign Buzzer    = |Ringing;
  assign RingValid = |Ringing;
  assign StopHold  = (hold_q != '0);

endmodule

// File: tb/tb_alarm_sequencer.sv
// Scoreboard bench for alarm_sequencer: directed stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_alarm_sequencer;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       Tick = 1'b0;
  logic [3:0] Match = '0;
  logic [3:0] Enable = '0;
  logic       SnzBtn = 1'b0;
  logic       StopBtn = 1'b0;
  logic [3:0] Ringing;
  logic [3:0] Snoozing;
  logic       Buzzer;
  logic       RingValid;
  logic [1:0] RingId;
  logic       StopHold;

  alarm_sequencer #(
    .NUM_ALARMS (4),
    .SNZ_TICKS  (300),
    .STOP_TICKS (3),
    .MAX_SNOOZE (3),
    .RING_TICKS (5)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Tick      (Tick),
    .Match     (Match),
    .Enable    (Enable),
    .SnzBtn    (SnzBtn),
    .StopBtn   (StopBtn),
    .Ringing   (Ringing),
    .Snoozing  (Snoozing),
    .Buzzer    (Buzzer),
    .RingValid (RingValid),
    .RingId    (RingId),
    .StopHold  (StopHold)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    int         cyc;
    logic [3:0] ring;
    logic [3:0] snz;
    logic       hold;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  function automatic logic [1:0] low_id(input logic [3:0] r);
    logic [1:0] id;
    id = 2'd0;
    for (int i = 3; i >= 0; i--) if (r[i]) id = 2'(i);
    return id;
  endfunction

  task automatic expect_now(input string name, input logic [3:0] r, input logic [3:0] s,
                            input logic h);
    exp_t e;
    e.name = name;
    e.cyc  = cyc;
    e.ring = r;
    e.snz  = s;
    e.hold = h;
    exp_q.push_back(e);
  endtask

  always @(negedge Clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      mon_e = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL %s: not sampled in cycle %0d (now %0d)", mon_e.name, mon_e.cyc, cyc);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (Ringing !== mon_e.ring || Snoozing !== mon_e.snz || Buzzer !== (|mon_e.ring) ||
          RingValid !== (|mon_e.ring) || RingId !== low_id(mon_e.ring) ||
          StopHold !== mon_e.hold) begin
        failures++;
        $display("FAIL %s: got ring=%b snz=%b buz=%b vld=%b id=%0d hold=%b, want ring=%b snz=%b buz=%b vld=%b id=%0d hold=%b",
                 mon_e.name, Ringing, Snoozing, Buzzer, RingValid, RingId, StopHold,
                 mon_e.ring, mon_e.snz, |mon_e.ring, |mon_e.ring, low_id(mon_e.ring),
                 mon_e.hold);
      end
    end
  end

  task automatic clk1();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick1();
    Tick = 1'b1;
    clk1();
    Tick = 1'b0;
  endtask

  // Press snooze on ringing ch1, then let the snooze period run out.
  task automatic snooze_round(input string tag);
    SnzBtn = 1'b1;
    clk1();
    expect_now({tag, "_snooze"}, 4'b0000, 4'b0010, 1'b0);
    SnzBtn = 1'b0;
    clk1();
    repeat (299) tick1();
    expect_now({tag, "_tick299"}, 4'b0000, 4'b0010, 1'b0);
    tick1();
    expect_now({tag, "_tick300"}, 4'b0010, 4'b0000, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clk1();
    expect_now("reset", 4'b0000, 4'b0000, 1'b0);
    clk1();
    Rst_n = 1'b1;
    clk1();

    Enable = 4'b0010;
    Match  = 4'b0010;
    clk1();
    Match = '0;
    expect_now("ring_ch1", 4'b0010, 4'b0000, 1'b0);

    snooze_round("snz1");
    snooze_round("snz2");
    snooze_round("snz3");
    SnzBtn = 1'b1;
    clk1();
    expect_now("snz4_ignored", 4'b0010, 4'b0000, 1'b0);
    SnzBtn = 1'b0;
    clk1();

    // ch1 disabled, ch0 and ch2 ring
    Enable = 4'b0101;
    Match  = 4'b0101;
    clk1();
    Match = '0;
    expect_now("ring_ch0_ch2", 4'b0101, 4'b0000, 1'b0);

    StopBtn = 1'b1;
    tick1();
    expect_now("hold1_t1", 4'b0101, 4'b0000, 1'b1);
    tick1();
    expect_now("hold1_t2", 4'b0101, 4'b0000, 1'b1);
    StopBtn = 1'b0;
    clk1();
    expect_now("hold_release", 4'b0101, 4'b0000, 1'b0);
    StopBtn = 1'b1;
    tick1();
    expect_now("hold2_t1", 4'b0101, 4'b0000, 1'b1);
    tick1();
    expect_now("hold2_t2", 4'b0101, 4'b0000, 1'b1);
    tick1();
    expect_now("stop_done", 4'b0000, 4'b0000, 1'b0);

    // Button still held: counter must stay inhibited
    Match = 4'b0001;
    clk1();
    Match = '0;
    expect_now("ring_while_inhibit", 4'b0001, 4'b0000, 1'b0);
    repeat (3) tick1();
    expect_now("inhibited", 4'b0001, 4'b0000, 1'b0);
    StopBtn = 1'b0;
    Enable  = 4'b0000;
    clk1();
    Enable = 4'b0101;
    Match  = 4'b0001;
    clk1();
    Match = '0;
    expect_now("ch0_rearm", 4'b0001, 4'b0000, 1'b0);

    StopBtn = 1'b1;
    tick1();
    tick1();
    Tick   = 1'b1;
    SnzBtn = 1'b1;
    clk1();
    Tick = 1'b0;
    expect_now("stop_vs_snz", 4'b0000, 4'b0000, 1'b0);
    StopBtn = 1'b0;
    SnzBtn  = 1'b0;
    clk1();

    Match = 4'b0001;
    clk1();
    Match = '0;
    expect_now("ch0_ring", 4'b0001, 4'b0000, 1'b0);
    SnzBtn = 1'b1;
    clk1();
    expect_now("ch0_snooze", 4'b0000, 4'b0001, 1'b0);
    SnzBtn = 1'b0;
    Enable = 4'b0100;
    clk1();
    expect_now("en_drop_snooze", 4'b0000, 4'b0000, 1'b0);

    Match = 4'b0100;
    clk1();
    Match = '0;
    expect_now("ch2_ring", 4'b0100, 4'b0000, 1'b0);
    SnzBtn = 1'b1;
    clk1();
    expect_now("ch2_snooze", 4'b0000, 4'b0100, 1'b0);
    SnzBtn = 1'b0;
    Match  = 4'b0100;
    clk1();
    Match = '0;
    expect_now("match_in_snooze", 4'b0000, 4'b0100, 1'b0);

    Enable = 4'b1000;
    Match  = 4'b1000;
    clk1();
    Match = '0;
    expect_now("ch3_ring", 4'b1000, 4'b0000, 1'b0);
`ifdef ALARM_SEQ_AUTOSTOP_EN
    repeat (4) tick1();
    expect_now("autostop_t4", 4'b1000, 4'b0000, 1'b0);
    tick1();
    expect_now("autostop_t5", 4'b0000, 4'b0000, 1'b0);
`else
    repeat (1000) tick1();
    expect_now("persist_1000", 4'b1000, 4'b0000, 1'b0);
`endif

    Match = 4'b1000;
    clk1();
    Match = '0;
    expect_now("ring_again", 4'b1000, 4'b0000, 1'b0);
    clk1();
    Rst_n = 1'b0;
    #1;
    expect_now("async_reset", 4'b0000, 4'b0000, 1'b0);
    clk1();
    Rst_n = 1'b1;

    repeat (3) clk1();
    if (exp_q.size() != 0) begin
      checks   += exp_q.size();
      failures += exp_q.size();
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
